instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the combinational program ROM.
- Owns the program counter (PC) and drives the ROM address. It registers the returned 28-bit instruction into an instruction register for the decode/execute stage.
- Handles stall, branch/jump redirect with flush, and halt.
- Supplies the execute stage with the instruction plus its own address.

---
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational ROM address and registers the returned
// instruction (plus its address) for decode/execute. Handles stall, branch flush and halt.
module instruction_fetch_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          INSTR_W  = 28,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oRomAddress,
  input  logic [INSTR_W-1:0] iRomInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic               iHalt,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic               oHalted
);

  typedef enum logic {StRun, StHalt} state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic                 r_valid;
  logic                 r_halted;
  logic                 w_branch;

  // A redirect only counts when the execute stage is acting on a live instruction.
  assign w_branch = iBranchTaken && r_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (iHalt) begin
            r_state  <= StHalt;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_branch) begin
            // Flush the word fetched from the old PC; one bubble before the target issues.
            r_pc    <= iBranchTarget;
            r_instr <= '0;
            r_valid <= 1'b0;
          end else if (!iStall) begin
            r_instr    <= iRomInstruction;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 1'b1;
          end
        end
        StHalt: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign oRomAddress  = r_pc;
  assign oInstruction = r_instr;
  assign oPC          = r_instr_pc;
  assign oValid       = r_valid;
  assign oHalted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit: a transaction-level model predicts the outputs
// after every edge, pushes them into a queue, and a monitor compares them against the DUT.
module tb_instruction_fetch_unit;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 28;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic [ADDR_W-1:0]  oRomAddress;
  logic [INSTR_W-1:0] iRomInstruction;
  logic               iStall = 1'b0;
  logic               iBranchTaken = 1'b0;
  logic [ADDR_W-1:0]  iBranchTarget = '0;
  logic               iHalt = 1'b0;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oValid;
  logic               oHalted;

  instruction_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(16'd0)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .oRomAddress    (oRomAddress),
    .iRomInstruction(iRomInstruction),
    .iStall         (iStall),
    .iBranchTaken   (iBranchTaken),
    .iBranchTarget  (iBranchTarget),
    .iHalt          (iHalt),
    .oInstruction   (oInstruction),
    .oPC            (oPC),
    .oValid         (oValid),
    .oHalted        (oHalted)
  );

  always #5 Clock = ~Clock;

  int unsigned rom_seed = 32'h1234_5678;

  function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    case (a)
      16'd0: return 28'h0000FA0;
      16'd1: return 28'h1A70001;
      16'd2: return 28'h1A30001;
      16'd3: return 28'h1A403E8;
      default: begin
        h = ({16'd0, a} * 32'h9E37_79B1) ^ rom_seed;
        return h[INSTR_W-1:0];
      end
    endcase
  endfunction

  assign iRomInstruction = rom_word(oRomAddress);

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               instr_known;
    logic [ADDR_W-1:0]  opc;
    logic               opc_known;
    logic               valid;
    logic               halted;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what the fetch unit should present after the most recent edge.
  logic [ADDR_W-1:0]  m_pc = '0;
  logic [INSTR_W-1:0] m_instr = '0;
  logic               m_ik = 1'b0;
  logic [ADDR_W-1:0]  m_opc = '0;
  logic               m_pk = 1'b0;
  logic               m_valid = 1'b0;
  logic               m_halted = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic [ADDR_W-1:0] tg, input logic hl);
    exp_t e;
    @(negedge Clock);
    Reset = rst; iStall = st; iBranchTaken = bt; iBranchTarget = tg; iHalt = hl;
    if (rst) begin
      m_pc = 16'd0; m_instr = '0; m_ik = 1'b1; m_opc = '0; m_pk = 1'b1;
      m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (hl) begin
      m_halted = 1'b1; m_valid = 1'b0; m_ik = 1'b0; m_pk = 1'b0;
    end else if (bt && m_valid) begin
      m_pc = tg; m_valid = 1'b0; m_instr = '0; m_ik = 1'b1; m_pk = 1'b0;
    end else if (!st) begin
      m_instr = rom_word(m_pc); m_ik = 1'b1;
      m_opc = m_pc; m_pk = 1'b1;
      m_valid = 1'b1;
      m_pc = m_pc + 16'd1;
    end
    e.pc = m_pc; e.instr = m_instr; e.instr_known = m_ik; e.opc = m_opc;
    e.opc_known = m_pk; e.valid = m_valid; e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  // Runs unstalled until the model shows a live instruction at address a.
  task automatic run_until_opc(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    while (!(m_valid && m_pk && m_opc == a) && n < 40) begin
      step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_errors++;
      $display("FAIL reach_opc: opc=%h valid=%0b, required opc=%h within 40 cycles",
               m_opc, m_valid, a);
    end
  endtask

  always @(posedge Clock) begin
    exp_t e;
    cycle++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (oRomAddress !== e.pc || oValid !== e.valid || oHalted !== e.halted ||
          (e.instr_known && oInstruction !== e.instr) || (e.opc_known && oPC !== e.opc)) begin
        n_errors++;
        $display("FAIL cycle%0d outputs: got addr=%h instr=%h pc=%h v=%0b h=%0b, required addr=%h instr=%h(%0b) pc=%h(%0b) v=%0b h=%0b",
                 cycle, oRomAddress, oInstruction, oPC, oValid, oHalted,
                 e.pc, e.instr, e.instr_known, e.opc, e.opc_known, e.valid, e.halted);
      end
    end
  end

  initial begin
    rom_seed = $urandom;
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    run(4);
    // Stall for three cycles with oPC=2.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    run_until_opc(16'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    run(2);
    // Branch to 8 while oPC=11.
    run_until_opc(16'd11);
    step(1'b0, 1'b0, 1'b1, 16'd8, 1'b0);
    run(3);
    // Branch together with stall, then a branch seen while oValid=0 must be ignored.
    step(1'b0, 1'b1, 1'b1, 16'd20, 1'b0);
    run(2);
    step(1'b0, 1'b0, 1'b1, 16'd30, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'd40, 1'b0);
    run(3);
    // Wrap-around through 0xFFFF; also branch to the current PC.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    run(3);
    step(1'b0, 1'b0, 1'b1, m_pc, 1'b0);
    run(2);
    // Halt at oPC=5, toggle everything for 10 cycles, then a one-cycle reset.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    run_until_opc(16'd5);
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    run(5);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [ADDR_W-1:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                       : 16'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, tg, $urandom_range(0, 149) == 0);
      if (m_halted && $urandom_range(0, 7) == 0) step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    end
    @(posedge Clock);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
